// File: rtl/cmp_serial_4bit.sv
// cmp_serial_4bit: MSB-first bit-serial magnitude comparator with start/done handshake.
// Walks one bit per clock from the MSB down and stops at the first differing bit.
// Optional feature macro: CMP_SIGNED_EN (two's complement operands; MSB=1 is the lesser
// at the sign step, and signa/signb carry the captured MSBs). Undefined: unsigned operands.
module cmp_serial_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             agtb,
   output logic             altb,
   output logic             aeqb,
   output logic             signa,
   output logic             signb
);

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      EVAL = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [IW-1:0]    idx;

   // Per-bit "A has the 1" / "B has the 1" vectors; the walker just selects one entry.
   logic [WIDTH-1:0] bit_gt;
   logic [WIDTH-1:0] bit_lt;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign bit_gt[gi] = ra[gi] & ~rb[gi];
         assign bit_lt[gi] = ~ra[gi] & rb[gi];
      end
   endgenerate

   logic cur_gt;
   logic cur_lt;
   logic at_msb;
   logic step_gt;
   logic step_lt;
   logic cap_signa;
   logic cap_signb;

   assign cur_gt = bit_gt[idx];
   assign cur_lt = bit_lt[idx];
   assign at_msb = (idx == MSB_IDX);

`ifdef CMP_SIGNED_EN
   // At the sign step a set MSB marks the negative, hence lesser, operand.
   assign step_gt   = at_msb ? cur_lt : cur_gt;
   assign step_lt   = at_msb ? cur_gt : cur_lt;
   assign cap_signa = a[WIDTH-1];
   assign cap_signb = b[WIDTH-1];
`else
   assign step_gt   = cur_gt;
   assign step_lt   = cur_lt;
   assign cap_signa = 1'b0;
   assign cap_signb = 1'b0;
`endif

   // Handshake FSM: capture operands on accept, then evaluate one bit per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         agtb  <= 1'b0;
         altb  <= 1'b0;
         aeqb  <= 1'b0;
         signa <= 1'b0;
         signb <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  idx   <= MSB_IDX;
                  signa <= cap_signa;
                  signb <= cap_signb;
                  busy  <= 1'b1;
                  state <= EVAL;
               end
            end
            EVAL: begin
               if (step_gt || step_lt || (idx == '0)) begin
                  // Deciding step: flags are one-hot and held until the next completion.
                  agtb  <= step_gt;
                  altb  <= step_lt;
                  aeqb  <= ~(step_gt | step_lt);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_serial_4bit.sv
// tb_cmp_serial_4bit: directed-vector bench for cmp_serial_4bit (either build of CMP_SIGNED_EN).
module tb_cmp_serial_4bit;

`ifdef CMP_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic       agtb;
   logic       altb;
   logic       aeqb;
   logic       signa;
   logic       signb;

   int         n_tests;
   int         n_fail;
   logic [2:0] prev_flags;   // {agtb, altb, aeqb} expected to be held from last completion

   cmp_serial_4bit #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .agtb  (agtb),
      .altb  (altb),
      .aeqb  (aeqb),
      .signa (signa),
      .signb (signb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One compare: called from a point just after an edge; start is presented for one edge.
   task automatic run_cmp(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                          input int lat, input logic [2:0] expf,
                          input logic sa, input logic sb);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      tick();                                   // E0
      start = 1'b0;
      check({tag, ".e0_busy"}, busy, 1);
      check({tag, ".e0_done"}, done, 0);
      check({tag, ".e0_held"}, {agtb, altb, aeqb}, prev_flags);
      check({tag, ".signs"}, {signa, signb}, {sa, sb});
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k < lat) begin
            check({tag, ".mid_done"}, done, 0);
         end else begin
            check({tag, ".done"}, done, 1);
            check({tag, ".busy_fall"}, busy, 0);
            check({tag, ".flags"}, {agtb, altb, aeqb}, expf);
         end
      end
      prev_flags = expf;
      $display("[TB] %s a=%b b=%b lat=%0d flags(gt,lt,eq)=%b", tag, ta, tb_v, lat,
               {agtb, altb, aeqb});
   endtask

   initial begin
      int dcount;
      n_tests    = 0;
      n_fail     = 0;
      prev_flags = 3'b000;
      rst_n      = 1'b0;
      start      = 1'b0;
      a          = 4'h0;
      b          = 4'h0;
      repeat (2) tick();
      check("rst.outs", {busy, done, agtb, altb, aeqb, signa, signb}, 7'b0);
      rst_n = 1'b1;
      tick();

      // Equal operands: full-width walk.
      run_cmp("eq0", 4'b0000, 4'b0000, 4, 3'b001, 1'b0, 1'b0);
      tick();
      check("eq0.done_pulse", done, 0);

      // Negative operands, decided at bit1.
      run_cmp("neg", 4'b1000, 4'b1011, 3, 3'b010, SGN, SGN);
      tick();

      // Sign-bit decision at E1.
      run_cmp("sgn", 4'b0101, 4'b1111, 1, SGN ? 3'b100 : 3'b010, 1'b0, SGN);
      tick();

      // Mid-width decision then back-to-back start inside the done cycle.
      run_cmp("mid", 4'b0010, 4'b0111, 2, 3'b010, 1'b0, 1'b0);
      run_cmp("b2b", 4'b0111, 4'b0010, 2, 3'b100, 1'b0, 1'b0);
      tick();

      // LSB-only differences: maximum latency with a decision.
      run_cmp("lsb_lt", 4'b0110, 4'b0111, 4, 3'b010, 1'b0, 1'b0);
      tick();
      run_cmp("lsb_gt", 4'b1001, 4'b1000, 4, 3'b100, SGN, SGN);
      tick();

      // Busy protection: ignored start and late operand change.
      start = 1'b1;
      a = 4'b0000;
      b = 4'b0000;
      tick();                                   // E0
      start = 1'b0;
      dcount = 0;
      tick();                                   // E1
      start = 1'b1;
      a = 4'b1111;
      tick();                                   // E2
      start = 1'b0;
      a = 4'b1111;
      tick();                                   // E3
      check("busyp.e3_busy", busy, 1);
      check("busyp.e3_done", done, 0);
      tick();                                   // E4
      check("busyp.e4_done", done, 1);
      check("busyp.flags", {agtb, altb, aeqb}, 3'b001);
      for (int k = 0; k < 4; k++) begin
         if (done) dcount++;
         tick();
      end
      check("busyp.one_done", dcount, 1);
      check("busyp.idle", busy, 0);
      $display("[TB] busyp a=0000 b=0000 flags(gt,lt,eq)=%b done_pulses=%0d",
               {agtb, altb, aeqb}, dcount);
      prev_flags = 3'b001;

      // Reset mid-compare.
      start = 1'b1;
      a = 4'b0000;
      b = 4'b0000;
      tick();                                   // E0
      start = 1'b0;
      tick();                                   // E1
      tick();                                   // E2
      rst_n = 1'b0;
      #1;
      check("rstmid.outs", {busy, done, agtb, altb, aeqb, signa, signb}, 7'b0);
      tick();
      rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done) dcount++;
      end
      check("rstmid.no_done", dcount, 0);
      check("rstmid.idle", {busy, agtb, altb, aeqb}, 4'b0);
      $display("[TB] rstmid aborted compare, done_pulses=%0d", dcount);
      prev_flags = 3'b000;
      run_cmp("fresh", 4'b0101, 4'b1111, 1, SGN ? 3'b100 : 3'b010, 1'b0, SGN);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
